// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared constants and helpers for the cpu_mem memory/MMIO target.
//   - MMIO window base and register slot indices (decoded on addr[3:2])
//   - STATUS bit positions
//   - lane_shift(): moves low-aligned byte strobes into their lanes and
//     flags the misaligned halfword/word patterns
package cpu_mem_pkg;

   localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;

   localparam logic [1:0]  REG_CONSOLE = 2'd0;
   localparam logic [1:0]  REG_CYCLE   = 2'd1;
   localparam logic [1:0]  REG_STATUS  = 2'd2;

   localparam int ST_MISALIGN = 0;
   localparam int ST_OVERFLOW = 1;
   localparam int ST_BITS     = 2;

   typedef struct packed {
      logic       misaligned;
      logic [3:0] lanes;
   } lane_shift_t;

   // Strobes pushed past lane 3 are simply lost.
   function automatic lane_shift_t lane_shift(input logic [3:0] wstrb,
                                              input logic [1:0] off);
      lane_shift_t r;
      logic [7:0]  wide;
      wide         = {4'b0000, wstrb} << off;
      r.lanes      = wide[3:0];
      r.misaligned = ((wstrb == 4'b0011) && off[0]) ||
                     ((wstrb == 4'b1111) && (off != 2'd0));
      return r;
   endfunction

endpackage

// File: rtl/cpu_mem_fifo.sv
// cpu_mem_fifo: small synchronous FIFO used as the console byte queue.
//   clk_i, rst_i (async, active-high)
//   push_i/data_i : enqueue; accepted when not full, or when full with a pop
//   pop_i         : dequeue; ignored when empty
//   data_o        : head entry (meaningless while empty_o)
//   full_o, empty_o, count_o : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module cpu_mem_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [PW:0]      count_o
);

   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign data_o  = mem_q[rd_q];

   assign do_pop  = pop_i && !empty_o;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/cpu_mem.sv
// cpu_mem: word-organised RAM plus a small MMIO window behind the core's
// single-port memory bus. Read data has a fixed one-cycle latency.
//   clk_i, rst_i (async, active-high)
//   enable_i, wstrb_i (0 = read), addr_i, wvalue_i : request, low-aligned
//   rvalue_o        : low-aligned read data, the cycle after a read; held
//   console_data_o/console_valid_o/console_ready_i : console FIFO head
//   err_o           : registered OR of the sticky STATUS bits
// MMIO (addr[31]=1, slot = addr[3:2]): 0 CONSOLE, 1 CYCLE, 2 STATUS (W1C), 3 zero.
// Build option: define CPU_MEM_CYCLE_CNT_EN to build the CYCLE counter;
// otherwise CYCLE reads 0 like slot 3.
module cpu_mem
   import cpu_mem_pkg::*;
#(
   parameter int    RAM_WORDS  = 4096,
   parameter int    FIFO_DEPTH = 4,
   parameter string INIT_FILE  = ""
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        enable_i,
   input  logic [3:0]  wstrb_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wvalue_i,
   output logic [31:0] rvalue_o,
   output logic [7:0]  console_data_o,
   output logic        console_valid_o,
   input  logic        console_ready_i,
   output logic        err_o
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0] ram_q [RAM_WORDS];

   // ---- request decode ----
   logic [1:0]    off, slot;
   logic [AW-1:0] widx;
   logic          is_mmio, is_wr, is_rd, wr_ok;
   lane_shift_t   ls;
   logic [31:0]   wdata_sh;
   logic          unused_addr;

   assign off         = addr_i[1:0];
   assign slot        = addr_i[3:2];
   assign widx        = addr_i[AW+1:2];
   assign is_mmio     = (addr_i[31] == MMIO_BASE[31]);
   assign is_wr       = enable_i && (wstrb_i != 4'b0000);
   assign is_rd       = enable_i && (wstrb_i == 4'b0000);
   assign ls          = lane_shift(wstrb_i, off);
   assign wr_ok       = is_wr && !ls.misaligned;
   assign wdata_sh    = wvalue_i << {off, 3'b000};
   assign unused_addr = ^addr_i[30:AW+2];

   // ---- RAM ----
   always_ff @(posedge clk_i) begin
      if (wr_ok && !is_mmio) begin
         for (int b = 0; b < 4; b++)
            if (ls.lanes[b]) ram_q[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
   end

   // ---- console FIFO ----
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;

   assign fifo_push       = wr_ok && is_mmio && (slot == REG_CONSOLE);
   assign fifo_pop        = console_valid_o && console_ready_i;
   assign console_valid_o = !fifo_empty;

   cpu_mem_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (wvalue_i[7:0]),
      .pop_i   (fifo_pop),
      .data_o  (console_data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // ---- cycle counter ----
   logic [31:0] cyc_rd;
`ifdef CPU_MEM_CYCLE_CNT_EN
   logic [31:0] cyc_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cyc_q <= '0;
      else       cyc_q <= cyc_q + 32'd1;
   end
   assign cyc_rd = cyc_q;
`else
   assign cyc_rd = '0;
`endif

   // ---- STATUS ----
   logic [ST_BITS-1:0] status_q, status_d, status_set, status_clr;

   always_comb begin
      status_set              = '0;
      status_set[ST_MISALIGN] = is_wr && ls.misaligned;
      status_set[ST_OVERFLOW] = fifo_push && fifo_full && !fifo_pop;
      status_clr              = '0;
      if (wr_ok && is_mmio && (slot == REG_STATUS) && ls.lanes[0])
         status_clr = wdata_sh[ST_BITS-1:0];
      // set wins over a same-cycle clear
      status_d = (status_q & ~status_clr) | status_set;
   end

   // ---- read path ----
   logic [31:0] rword_q, rword_d;
   logic [1:0]  roff_q;
   logic        err_q;

   always_comb begin
      rword_d = ram_q[widx];
      if (is_mmio) begin
         unique case (slot)
            REG_CONSOLE: rword_d = {16'h0000, 8'(fifo_count), 7'b0000000, fifo_full};
            REG_CYCLE:   rword_d = cyc_rd;
            REG_STATUS:  rword_d = {{(32-ST_BITS){1'b0}}, status_q};
            default:     rword_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rword_q  <= '0;
         roff_q   <= '0;
         status_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (is_rd) begin
            rword_q <= rword_d;
            roff_q  <= off;
         end
         status_q <= status_d;
         err_q    <= |status_q;
      end
   end

   assign rvalue_o = rword_q >> {roff_q, 3'b000};
   assign err_o    = err_q;

endmodule

// File: tb/tb_cpu_mem.sv
module tb_cpu_mem;

   localparam int RW    = 64;
   localparam int DEPTH = 4;
   localparam logic [31:0] CONS = 32'h8000_0000;
   localparam logic [31:0] CYCR = 32'h8000_0004;
   localparam logic [31:0] STAT = 32'h8000_0008;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        enable_i;
   logic [3:0]  wstrb_i;
   logic [31:0] addr_i, wvalue_i, rvalue_o;
   logic [7:0]  console_data_o;
   logic        console_valid_o, console_ready_i, err_o;

   always #5 clk_i = ~clk_i;

   cpu_mem #(.RAM_WORDS(RW), .FIFO_DEPTH(DEPTH), .INIT_FILE("")) dut (
      .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .wstrb_i(wstrb_i),
      .addr_i(addr_i), .wvalue_i(wvalue_i), .rvalue_o(rvalue_o),
      .console_data_o(console_data_o), .console_valid_o(console_valid_o),
      .console_ready_i(console_ready_i), .err_o(err_o));

   int vectors = 0, miscompares = 0;

   // reference model state
   logic [31:0] mw [RW];
   logic [7:0]  mq[$];
   logic [31:0] expq[$];
   logic [1:0]  st;
   logic        err_exp, pop_pend, rd_seen;
   logic [31:0] last_rd, cyc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   // a read issued at an edge produces data visible after that edge
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cyc     <= 0;
         rd_seen <= 1'b0;
      end else begin
         cyc     <= cyc + 1;
         rd_seen <= enable_i && (wstrb_i == 4'b0000);
      end
   end

   // monitor: checks every cycle, pops the read and console scoreboards
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (rd_seen) begin
            if (expq.size() == 0) begin
               miscompares++; vectors++;
               $display("FAIL rd_noexp: read data with empty scoreboard");
            end else last_rd = expq.pop_front();
         end
         chk("rvalue", rvalue_o, last_rd);
         chk("cvalid", {31'b0, console_valid_o}, {31'b0, mq.size() != 0});
         chk("err", {31'b0, err_o}, {31'b0, err_exp});
         pop_pend = 1'b0;
         if (console_valid_o && console_ready_i && mq.size() > 0) begin
            chk("cdata", {24'h0, console_data_o}, {24'h0, mq.pop_front()});
            pop_pend = 1'b1;
         end
      end
   end

   function automatic logic [31:0] cyc_model();
`ifdef CPU_MEM_CYCLE_CNT_EN
      return cyc;
`else
      return 32'h0;
`endif
   endfunction

   task automatic step(input logic en, input logic [3:0] ws, input logic [31:0] a,
                       input logic [31:0] wv, input logic rdy);
      int off, idx, cnt;
      logic [1:0] set, clr;
      logic [31:0] w;
      enable_i = en; wstrb_i = ws; addr_i = a; wvalue_i = wv; console_ready_i = rdy;
      @(posedge clk_i);
      off = int'(a[1:0]);
      idx = int'((a >> 2) % 32'(RW));
      cnt = mq.size() + (pop_pend ? 1 : 0);
      set = 2'b00; clr = 2'b00; w = 32'h0;
      err_exp = (st != 2'b00);
      if (en && ws != 4'b0000) begin
         if ((ws == 4'b0011 && (off % 2) == 1) || (ws == 4'b1111 && off != 0)) set[0] = 1'b1;
         else if (!a[31]) begin
            for (int i = 0; i < 4; i++)
               if (ws[i] && (i + off) < 4) mw[idx][8*(i+off) +: 8] = wv[8*i +: 8];
         end else begin
            case (a[3:2])
               2'd0: if (mq.size() == DEPTH) set[1] = 1'b1; else mq.push_back(wv[7:0]);
               2'd2: if (off == 0 && ws[0]) clr = wv[1:0];
               default: ;
            endcase
         end
      end else if (en) begin
         if (!a[31]) w = mw[idx];
         else begin
            case (a[3:2])
               2'd0: w = {16'h0, 8'(cnt), 7'h0, cnt == DEPTH};
               2'd1: w = cyc_model();
               2'd2: w = {30'h0, st};
               default: w = 32'h0;
            endcase
         end
         expq.push_back(w >> (8*off));
      end
      st = (st & ~clr) | set;
      #1;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 32'h0, rdy);
   endtask

   task automatic do_reset();
      enable_i = 1'b0; wstrb_i = 4'h0; console_ready_i = 1'b0;
      rst_i = 1'b1;
      mq.delete(); expq.delete();
      st = 2'b00; err_exp = 1'b0; pop_pend = 1'b0; last_rd = 32'h0;
      #1;
      chk("rst_rvalue", rvalue_o, 32'h0);
      chk("rst_cvalid", {31'b0, console_valid_o}, 32'h0);
      chk("rst_err", {31'b0, err_o}, 32'h0);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (mq.size() > 0 && n < 50) begin
         idle(1, 1'b1);
         n++;
      end
      idle(2, 1'b1);
      chk("drained", {31'b0, console_valid_o}, 32'h0);
   endtask

   logic [31:0] ca;

   initial begin
      rst_i = 1'b0; enable_i = 1'b0; wstrb_i = 4'h0; addr_i = 32'h0; wvalue_i = 32'h0;
      console_ready_i = 1'b0; st = 2'b00; err_exp = 1'b0; pop_pend = 1'b0; last_rd = 32'h0;
      #2 do_reset();

      for (int w = 0; w < RW; w++) step(1'b1, 4'hF, 32'(w * 4), $urandom, 1'b0);

      // lane shifting
      step(1'b1, 4'hF, 32'h10, 32'hAABBCCDD, 1'b0);
      step(1'b1, 4'h0, 32'h10, 32'h0, 1'b0); chk("tp_rd10", rvalue_o, 32'hAABBCCDD);
      step(1'b1, 4'h0, 32'h11, 32'h0, 1'b0); chk("tp_rd11", rvalue_o, 32'h00AABBCC);
      step(1'b1, 4'h0, 32'h13, 32'h0, 1'b0); chk("tp_rd13", rvalue_o, 32'h000000AA);
      step(1'b1, 4'h1, 32'h12, 32'h5A, 1'b0);
      step(1'b1, 4'h0, 32'h10, 32'h0, 1'b0); chk("tp_byte", rvalue_o, 32'hAA5ACCDD);
      step(1'b1, 4'h3, 32'h12, 32'h1234, 1'b0);
      step(1'b1, 4'h0, 32'h10, 32'h0, 1'b0); chk("tp_half", rvalue_o, 32'h1234CCDD);
      // wrap alias of word 4
      step(1'b1, 4'h0, 32'h10 + 32'(RW * 4), 32'h0, 1'b0); chk("tp_wrap", rvalue_o, 32'h1234CCDD);

      // misaligned writes
      step(1'b1, 4'hF, 32'h21, 32'h11223344, 1'b0);
      step(1'b1, 4'h3, 32'h23, 32'h5566, 1'b0);
      step(1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
      step(1'b1, 4'h0, STAT, 32'h0, 1'b0); chk("tp_stat_mis", rvalue_o, 32'h1);
      idle(1, 1'b0); chk("tp_err_hi", {31'b0, err_o}, 32'h1);
      step(1'b1, 4'hF, STAT, 32'h1, 1'b0);
      idle(2, 1'b0);
      step(1'b1, 4'h0, STAT, 32'h0, 1'b0); chk("tp_stat_clr", rvalue_o, 32'h0);
      chk("tp_err_lo", {31'b0, err_o}, 32'h0);

      // console overflow
      for (int b = 0; b < 5; b++) step(1'b1, 4'h1, CONS, 32'(8'h41 + b), 1'b0);
      step(1'b1, 4'h0, CONS, 32'h0, 1'b0); chk("tp_cons_full", rvalue_o, 32'h00000401);
      step(1'b1, 4'h0, STAT, 32'h0, 1'b0); chk("tp_stat_ovf", rvalue_o, 32'h2);
      drain();
      step(1'b1, 4'hF, STAT, 32'h2, 1'b0);

      // full with simultaneous pop
      for (int b = 0; b < 4; b++) step(1'b1, 4'h1, CONS, 32'(8'h41 + b), 1'b0);
      step(1'b1, 4'h1, CONS, 32'h45, 1'b1);
      step(1'b1, 4'h0, CONS, 32'h0, 1'b0); chk("tp_cons_pp", rvalue_o, 32'h00000401);
      step(1'b1, 4'h0, STAT, 32'h0, 1'b0); chk("tp_no_ovf", rvalue_o, 32'h0);
      drain();

      // cycle counter
      step(1'b1, 4'h0, CYCR, 32'h0, 1'b0); ca = rvalue_o;
      idle(9, 1'b0);
      step(1'b1, 4'h0, CYCR, 32'h0, 1'b0);
`ifdef CPU_MEM_CYCLE_CNT_EN
      chk("tp_cyc_diff", rvalue_o - ca, 32'd10);
`else
      chk("tp_cyc_zero", rvalue_o | ca, 32'd0);
`endif

      // reset while a read result is on the bus
      step(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
      do_reset();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a;
         if ($urandom_range(0, 9) < 6) a = {1'b0, 31'($urandom)};
         else a = {1'b1, 27'($urandom), 4'($urandom)};
         step(1'b1 & ($urandom_range(0, 7) != 0), 4'($urandom), a, $urandom,
              1'($urandom_range(0, 1)));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
